pit_counter_channel: RTL

- Generalised 8254-style programmable interval timer channel; successor to the fixed mode-1 one-shot counter.
- Supports all six 8254 modes (0–5) with a parametrised count width.
- One instance per timer channel.
- Sits behind the chip's control-word/data-bus decode, which supplies the decoded mode, a count-write strobe and chip select.

---
 rtl/pit_pkg.sv | 36 +++
 rtl/pit_counter_channel_if.sv | 40 ++++
 rtl/pit_ce_decrement.sv | 41 ++++
 rtl/pit_counter_channel.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// rtl/pit_pkg.sv - shared types and helpers for the 8254-style timer channels
package pit_pkg;

  typedef enum logic [2:0] {
    MODE_INT_TC    = 3'd0,
    MODE_ONESHOT   = 3'd1,
    MODE_RATE      = 3'd2,
    MODE_SQUARE    = 3'd3,
    MODE_SW_STROBE = 3'd4,
    MODE_HW_STROBE = 3'd5
  } pit_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    HALT     = 2'd3
  } pit_state_e;

  // Raw mode codes 6 and 7 are aliases of the rate and square-wave modes.
  function automatic pit_mode_e pit_map_mode(input logic [2:0] raw);
    pit_mode_e m;
    case (raw)
      3'd6:    m = MODE_RATE;
      3'd7:    m = MODE_SQUARE;
      default: m = pit_mode_e'(raw);
    endcase
    return m;
  endfunction

  // Modes 1 and 5 are started by a gate rising edge instead of the write.
  function automatic logic pit_gate_triggered(input pit_mode_e m);
    return (m == MODE_ONESHOT) || (m == MODE_HW_STROBE);
  endfunction

endpackage

// File: rtl/pit_counter_channel_if.sv
// rtl/pit_counter_channel_if.sv - decode-side bus of one timer channel (bcd lane under BCD_COUNT_EN)
interface pit_counter_channel_if #(
  parameter int WIDTH = 16
);

  logic             cs;
  logic             wr_count;
  logic [WIDTH-1:0] count_in;
  logic [2:0]       mode;
  logic             gate;
`ifdef BCD_COUNT_EN
  logic             bcd;
`endif
  logic             out;
  logic [WIDTH-1:0] current_count;
  logic             gate_ck;

`ifdef BCD_COUNT_EN
  modport master (
    output cs, wr_count, count_in, mode, gate, bcd,
    input  out, current_count, gate_ck
  );

  modport slave (
    input  cs, wr_count, count_in, mode, gate, bcd,
    output out, current_count, gate_ck
  );
`else
  modport master (
    output cs, wr_count, count_in, mode, gate,
    input  out, current_count, gate_ck
  );

  modport slave (
    input  cs, wr_count, count_in, mode, gate,
    output out, current_count, gate_ck
  );
`endif

endinterface

// File: rtl/pit_ce_decrement.sv
// rtl/pit_ce_decrement.sv - combinational counting-element decrement by 1 or 2, binary or BCD
module pit_ce_decrement #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             step2_i,
  input  logic             bcd_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int DIGITS = WIDTH / 4;

  logic [WIDTH-1:0] bin_res;
  logic [WIDTH-1:0] bcd_res;
  logic             borrow;
  logic [4:0]       diff;

  // Binary subtraction wraps naturally from 0 to all-ones.
  assign bin_res = value_i - (step2_i ? WIDTH'(2) : WIDTH'(1));

  // Digit-wise BCD subtraction; a negative digit borrows and wraps by adding 10.
  always_comb begin
    bcd_res = '0;
    borrow  = 1'b0;
    diff    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      diff = {1'b0, value_i[4*i +: 4]} - {4'b0000, borrow}
             - ((i == 0) ? {3'b000, step2_i, ~step2_i} : 5'd0);
      if (diff[4]) begin
        bcd_res[4*i +: 4] = diff[3:0] + 4'd10;
        borrow            = 1'b1;
      end else begin
        bcd_res[4*i +: 4] = diff[3:0];
        borrow            = 1'b0;
      end
    end
  end

  assign result_o = bcd_i ? bcd_res : bin_res;

endmodule

// File: rtl/pit_counter_channel.sv
// rtl/pit_counter_channel.sv - one 8254-style timer channel, modes 0-5 (BCD counting under BCD_COUNT_EN)
module pit_counter_channel
  import pit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pit_counter_channel_if.slave  pit_if
);

  pit_state_e       state_q, state_d;
  pit_mode_e        mode_q, mode_d;
  pit_mode_e        mode_in;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] ce_q, ce_d;
  logic [WIDTH-1:0] ce_dec;
  logic             out_q, out_d;
  logic             gate_q;
  logic             gate_ck;
  logic             bcd_q, bcd_d;
  logic             bcd_in;
  logic             wr_en;
  logic             keep_state;
  logic             gate_trig;
  logic             periodic;
  logic             strobe_mode;
  logic             count_en;

`ifdef BCD_COUNT_EN
  assign bcd_in = pit_if.bcd;
`else
  assign bcd_in = 1'b0;
`endif

  assign wr_en       = pit_if.cs & pit_if.wr_count;
  assign mode_in     = pit_map_mode(pit_if.mode);
  assign gate_ck     = pit_if.gate & ~gate_q;
  assign gate_trig   = pit_gate_triggered(mode_q);
  assign periodic    = (mode_q == MODE_RATE) || (mode_q == MODE_SQUARE);
  assign strobe_mode = (mode_q == MODE_SW_STROBE) || (mode_q == MODE_HW_STROBE);
  // Gate level only qualifies counting in the software-loaded modes.
  assign count_en    = gate_trig | pit_if.gate;

  // A rewrite of the same running mode 1/2/3/5 only replaces N; it is picked up at the next reload or trigger.
  assign keep_state = wr_en && (mode_in == mode_q)
                      && ((state_q == COUNTING) || (state_q == HALT))
                      && (mode_in != MODE_INT_TC) && (mode_in != MODE_SW_STROBE);

  pit_ce_decrement #(
    .WIDTH (WIDTH)
  ) u_dec (
    .value_i  (ce_q),
    .step2_i  (mode_q == MODE_SQUARE),
    .bcd_i    (bcd_q),
    .result_o (ce_dec)
  );

  // State, count, CE and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_INT_TC;
      count_q <= '0;
      ce_q    <= '0;
      out_q   <= 1'b0;
      gate_q  <= 1'b0;
      bcd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      ce_q    <= ce_d;
      out_q   <= out_d;
      gate_q  <= pit_if.gate;
      bcd_q   <= bcd_d;
    end
  end

  // Next-state: write handling, load conditions and per-mode counting/output rules.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    ce_d    = ce_q;
    out_d   = out_q;
    bcd_d   = bcd_q;
    if (wr_en && !keep_state) begin
      count_d = pit_if.count_in;
      bcd_d   = bcd_in;
      mode_d  = mode_in;
      state_d = ARMED;
      out_d   = (mode_in != MODE_INT_TC);
    end else begin
      if (wr_en) begin
        count_d = pit_if.count_in;
        bcd_d   = bcd_in;
      end
      case (state_q)
        ARMED: begin
          if (!gate_trig) begin
            ce_d    = count_q;
            state_d = COUNTING;
          end else if (gate_ck) begin
            ce_d    = count_q;
            state_d = COUNTING;
            out_d   = (mode_q != MODE_ONESHOT);
          end
        end
        COUNTING, HALT: begin
          // The strobe of modes 4/5 lasts exactly one clock.
          if ((state_q == HALT) && strobe_mode) begin
            out_d = 1'b1;
          end
          if (gate_trig && gate_ck) begin
            ce_d    = count_q;
            state_d = COUNTING;
            out_d   = (mode_q != MODE_ONESHOT);
          end else if (periodic && !pit_if.gate) begin
            out_d = 1'b1;
          end else if (periodic && gate_ck) begin
            ce_d  = count_q;
            out_d = 1'b1;
          end else if (count_en) begin
            case (mode_q)
              MODE_RATE: begin
                if (ce_q == WIDTH'(1)) begin
                  ce_d  = count_q;
                  out_d = 1'b1;
                end else begin
                  ce_d  = ce_dec;
                  out_d = (ce_dec != WIDTH'(1));
                end
              end
              MODE_SQUARE: begin
                // Half-period ends when a step of 2 would reach or pass zero.
                // Odd N reloads N for the high half and N-1 for the low half;
                // bit 0 is also the parity of the least-significant BCD digit.
                if ((ce_q == WIDTH'(1)) || (ce_q == WIDTH'(2))) begin
                  if (count_q == WIDTH'(1)) begin
                    ce_d  = count_q;
                    out_d = 1'b1;
                  end else if (out_q) begin
                    ce_d  = count_q & ~WIDTH'(1);
                    out_d = 1'b0;
                  end else begin
                    ce_d  = count_q;
                    out_d = 1'b1;
                  end
                end else begin
                  ce_d = ce_dec;
                end
              end
              default: begin
                ce_d = ce_dec;
                if ((state_q == COUNTING) && (ce_dec == '0)) begin
                  state_d = HALT;
                  out_d   = (mode_q == MODE_INT_TC) || (mode_q == MODE_ONESHOT);
                end
              end
            endcase
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pit_if.out           = out_q;
  assign pit_if.current_count = ce_q;
  assign pit_if.gate_ck       = gate_ck;

endmodule
